// File: rtl/cpu_loader_pkg.sv
// rtl/cpu_loader_pkg.sv - command codes, state encoding and defaults for cpu_loader
package cpu_loader_pkg;

    localparam int DEF_LEN_W = 16;

    localparam logic [7:0] CMD_I = 8'h49;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_B = 8'h42;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_H = 8'h48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_BP_BYTES,
        ST_RUN
    } state_t;

endpackage

// File: rtl/cpu_loader_word_assembler.sv
// rtl/cpu_loader_word_assembler.sv - big-endian 8-to-32 word assembler
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_done
);

    logic [31:0] shreg;
    logic [1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= {shreg[23:0], byte_data};
            cnt   <= cnt + 2'd1;
        end
    end

    // Fires on the byte that completes the word; the full word is in shreg one cycle later.
    assign word_done = byte_valid && (cnt == 2'd3);
    assign word      = shreg;

endmodule

// File: rtl/cpu_loader.sv
// rtl/cpu_loader.sv - byte-command program loader and run/step/breakpoint controller for cpu_top
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter bit BP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] pc,
    output logic [31:0] addr,
    output logic [31:0] din,
    output logic        we_im,
    output logic        we_dm,
    output logic        debug,
    output logic        busy,
    output logic        bp_hit,
    output logic        err
);

    state_t             state, state_next;
    logic               accept;
    logic               target_dm;
    logic [7:0]         len_hi;
    logic [LEN_W-1:0]   count, count_load;
    logic [31:0]        bp_addr;
    logic               bp_valid;
    logic               first;
    logic               step_q;
    logic               bp_match, run_en, illegal;
    logic               asm_valid, asm_clear, word_done;
    logic [31:0]        asm_word;
    logic               err_q, bp_hit_q;

    assign accept     = rx_valid && rx_ready;
    assign rx_ready   = (state != ST_WRITE);
    assign busy       = (state != ST_IDLE);
    assign count_load = LEN_W'({len_hi, rx_data});

    // The first RUN cycle skips the compare so a resume from the breakpoint pc makes progress.
    assign bp_match = BP_EN && (state == ST_RUN) && bp_valid && (pc == bp_addr) && !first;
    assign run_en   = (state == ST_RUN) && !bp_match;
    assign debug    = !(run_en || step_q);

    assign we_im  = (state == ST_WRITE) && !target_dm;
    assign we_dm  = (state == ST_WRITE) && target_dm;
    assign din    = asm_word;
    assign err    = err_q;
    assign bp_hit = bp_hit_q;

    assign asm_valid = accept && ((state == ST_DATA) || (state == ST_BP_BYTES));
    assign asm_clear = accept && (state == ST_IDLE);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (rx_data),
        .byte_valid (asm_valid),
        .clear      (asm_clear),
        .word       (asm_word),
        .word_done  (word_done)
    );

    always_comb begin
        state_next = state;
        illegal    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (rx_data)
                        CMD_I, CMD_D: state_next = ST_LEN_HI;
                        CMD_B:        state_next = ST_BP_BYTES;
                        CMD_R:        state_next = ST_RUN;
                        CMD_S, CMD_C: state_next = ST_IDLE;
                        default:      illegal    = 1'b1;
                    endcase
                end
            end
            ST_LEN_HI:   if (accept) state_next = ST_LEN_LO;
            ST_LEN_LO:   if (accept) state_next = (count_load == '0) ? ST_IDLE : ST_DATA;
            ST_DATA:     if (word_done) state_next = ST_WRITE;
            ST_WRITE:    state_next = (count == LEN_W'(1)) ? ST_IDLE : ST_DATA;
            ST_BP_BYTES: if (word_done) state_next = ST_IDLE;
            ST_RUN: begin
                if (bp_match || (accept && (rx_data == CMD_H)))
                    state_next = ST_IDLE;
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            target_dm <= 1'b0;
            len_hi    <= '0;
            count     <= '0;
            bp_addr   <= '0;
            bp_valid  <= 1'b0;
            first     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            state    <= state_next;
            err_q    <= illegal;
            bp_hit_q <= bp_match;
            step_q   <= accept && (state == ST_IDLE) && (rx_data == CMD_S);
            first    <= (state == ST_IDLE) && (state_next == ST_RUN);

            if (accept && (state == ST_IDLE)) begin
                if ((rx_data == CMD_I) || (rx_data == CMD_D)) begin
                    target_dm <= (rx_data == CMD_D);
                    addr      <= '0;
                end
                if (rx_data == CMD_C)
                    bp_valid <= 1'b0;
            end
            if (accept && (state == ST_LEN_HI))
                len_hi <= rx_data;
            if (accept && (state == ST_LEN_LO))
                count <= count_load;
            if (state == ST_WRITE) begin
                addr  <= addr + 32'd1;
                count <= count - LEN_W'(1);
            end
            if ((state == ST_BP_BYTES) && word_done) begin
                bp_addr  <= {asm_word[23:0], rx_data};
                bp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// tb/tb_cpu_loader.sv - self-checking bench for cpu_loader
module tb_cpu_loader;
    import cpu_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] pc;
    logic [31:0] addr, din;
    logic        we_im, we_dm, debug, busy, bp_hit, err;

    always #5 clk = ~clk;

    cpu_loader #(.LEN_W(16), .BP_EN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .pc       (pc),
        .addr     (addr),
        .din      (din),
        .we_im    (we_im),
        .we_dm    (we_dm),
        .debug    (debug),
        .busy     (busy),
        .bp_hit   (bp_hit),
        .err      (err)
    );

    // CPU model: pc advances one instruction per ungated clock.
    always @(posedge clk) begin
        if (rst) pc <= 32'd0;
        else if (!debug) pc <= pc + 32'd4;
    end

    logic [64:0] wr_log [0:255];
    int wr_n = 0, low_cnt = 0, bp_cnt = 0, err_cnt = 0, viol = 0;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (we_im || we_dm) begin
                if (wr_n < 256) wr_log[wr_n] <= {we_dm, addr, din};
                wr_n <= wr_n + 1;
                if (!debug || (we_im && we_dm)) viol <= viol + 1;
            end
            if (!debug) low_cnt <= low_cnt + 1;
            if (bp_hit) bp_cnt <= bp_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
        end
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("send_timeout", 65'd0, 65'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    logic [31:0] ld_w [0:7];

    task automatic load(input logic dm, input int n);
        send(dm ? CMD_D : CMD_I);
        send(8'(n >> 8));
        send(8'(n));
        for (int i = 0; i < n; i++)
            for (int k = 3; k >= 0; k--)
                send(ld_w[i][8*k +: 8]);
        idle(3);
    endtask

    // Reference: word i of an N-word load lands at word address i of the chosen memory.
    task automatic expect_writes(input string name, input logic dm, input int n, input int base);
        check({name, "_count"}, 65'(wr_n - base), 65'(n));
        for (int i = 0; i < n; i++)
            check({name, "_word"}, wr_log[base + i], {dm, 32'(i), ld_w[i]});
    endtask

    typedef struct {
        logic [7:0] b;
        logic       e_err;
        logic       e_busy;
        logic       e_debug;
    } vec_t;

    vec_t tbl [0:6];

    initial begin
        int base, l0, b0, e0;
        logic [31:0] p0;
        logic [7:0]  rb;
        logic        dm;
        int          n;

        tbl[0] = '{8'h7F, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{CMD_C, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{CMD_S, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{CMD_H, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'h69, 1'b1, 1'b0, 1'b1};

        idle(3);
        check("rst_outs", {debug, busy, we_im, we_dm, bp_hit, err, rx_ready}, 65'b1000001);
        check("rst_addr", 65'(addr), 65'd0);
        check("rst_din", 65'(din), 65'd0);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].b);
            check($sformatf("tbl%0d_err", i), 65'(err), 65'(tbl[i].e_err));
            check($sformatf("tbl%0d_busy", i), 65'(busy), 65'(tbl[i].e_busy));
            check($sformatf("tbl%0d_debug", i), 65'(debug), 65'(tbl[i].e_debug));
            idle(1);
            check($sformatf("tbl%0d_err_clr", i), 65'(err), 65'd0);
        end

        ld_w[0] = 32'h12345678;
        ld_w[1] = 32'h9ABCDEF0;
        base = wr_n;
        load(1'b0, 2);
        expect_writes("load_im", 1'b0, 2, base);
        check("load_im_busy", 65'(busy), 65'd0);
        check("load_im_debug", 65'(debug), 65'd1);

        base = wr_n;
        send(CMD_D); send(8'h00); send(8'h00);
        check("len0_busy", 65'(busy), 65'd0);
        idle(3);
        check("len0_nowrite", 65'(wr_n - base), 65'd0);

        do_reset();
        send(CMD_B); send(8'h00); send(8'h00); send(8'h00); send(8'hC4);
        check("bp_set_busy", 65'(busy), 65'd0);
        b0 = bp_cnt;
        send(CMD_R);
        n = 0;
        while (!bp_hit && n < 200) begin
            idle(1);
            n++;
        end
        check("bp_reached", 65'(bp_hit), 65'd1);
        check("bp_pc", 65'(pc), 65'h0C4);
        check("bp_debug", 65'(debug), 65'd1);
        check("bp_busy", 65'(busy), 65'd0);
        idle(4);
        check("bp_pc_held", 65'(pc), 65'h0C4);
        check("bp_pulse_once", 65'(bp_cnt - b0), 65'd1);
        send(CMD_R);
        idle(5);
        check("resume_past_bp", 65'(pc > 32'h0C4), 65'd1);
        send(CMD_H);
        check("halt_debug", 65'(debug), 65'd1);
        check("halt_busy", 65'(busy), 65'd0);
        p0 = pc;
        idle(3);
        check("halt_pc_held", 65'(pc), 65'(p0));

        send(CMD_C);
        p0 = pc;
        l0 = low_cnt;
        for (int i = 0; i < 3; i++) begin
            send(CMD_S);
            idle(2);
        end
        check("step_windows", 65'(low_cnt - l0), 65'd3);
        check("step_pc", 65'(pc), 65'(p0 + 32'd12));

        send(CMD_I); send(8'h00); send(8'h03); send(8'h11); send(8'h22);
        rst = 1'b1;
        idle(1);
        check("midrst_outs", {debug, busy, we_im, we_dm, bp_hit, err}, 65'b100000);
        check("midrst_addr", 65'(addr), 65'd0);
        check("midrst_din", 65'(din), 65'd0);
        rst = 1'b0;
        ld_w[0] = 32'hAABBCCDD;
        base = wr_n;
        load(1'b1, 1);
        expect_writes("after_rst", 1'b1, 1, base);

        rx_data = CMD_I;
        rx_valid = 1'b1;
        rst = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        rst = 1'b0;
        check("rst_wins", 65'(busy), 65'd0);

        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                dm = 1'($urandom_range(0, 1));
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) ld_w[i] = $urandom;
                base = wr_n;
                load(dm, n);
                expect_writes($sformatf("rnd%0d", it), dm, n, base);
            end else begin
                do rb = 8'($urandom_range(0, 255));
                while (rb == CMD_I || rb == CMD_D || rb == CMD_B || rb == CMD_R ||
                       rb == CMD_S || rb == CMD_C);
                e0 = err_cnt;
                send(rb);
                idle(1);
                check($sformatf("rnd%0d_err", it), 65'(err_cnt - e0), 65'd1);
                check($sformatf("rnd%0d_busy", it), 65'(busy), 65'd0);
            end
        end

        check("write_while_running", 65'(viol), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
